// File: rtl/tcdm_g_pkg.sv
// Shared types and helpers for the TCDM wide-to-bank port splitter.
// Lane masks, lane slice offsets and TCDM write-enable encodings.
package tcdm_g_pkg;

  localparam int unsigned TCDM_SIZE = 4;

  localparam logic TCDM_WEN_STORE = 1'b0;
  localparam logic TCDM_WEN_LOAD  = 1'b1;

  typedef logic [TCDM_SIZE-1:0] lane_mask_t;

  // Bit offset of a lane inside a packed wide word.
  function automatic int unsigned lane_lo(
    int unsigned lane,
    int unsigned width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/tcdm_g_slave_split_if.sv
// Wide HWCE TCDM ports plus the split bank ports of the splitter.
// slave = splitter view, master = wide requester / bank side view.
interface tcdm_g_slave_split_if #(
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 32,
  parameter int unsigned BW   = DW / 8,
  parameter int unsigned SIZE = 4,
  parameter int unsigned NPX  = 4
);

  logic [NPX-1:0]                   slv_req_i;
  logic [NPX-1:0][AW-1:0]           slv_add_i;
  logic [NPX-1:0]                   slv_wen_i;
  logic [NPX-1:0][SIZE*DW-1:0]      slv_wdata_i;
  logic [NPX-1:0][SIZE*BW-1:0]      slv_be_i;
  logic [NPX-1:0]                   slv_gnt_o;
  logic [NPX-1:0]                   slv_r_valid_o;
  logic [NPX-1:0][SIZE*DW-1:0]      slv_r_rdata_o;

  logic [SIZE-1:0][NPX-1:0]         mst_req_o;
  logic [SIZE-1:0][NPX-1:0][AW-1:0] mst_add_o;
  logic [SIZE-1:0][NPX-1:0]         mst_wen_o;
  logic [SIZE-1:0][NPX-1:0][DW-1:0] mst_wdata_o;
  logic [SIZE-1:0][NPX-1:0][BW-1:0] mst_be_o;
  logic [SIZE-1:0][NPX-1:0]         mst_gnt_i;
  logic [SIZE-1:0][NPX-1:0]         mst_r_valid_i;
  logic [SIZE-1:0][NPX-1:0][DW-1:0] mst_r_rdata_i;

  modport slave (
    input  slv_req_i, slv_add_i, slv_wen_i,
    input  slv_wdata_i, slv_be_i,
    output slv_gnt_o, slv_r_valid_o, slv_r_rdata_o,
    output mst_req_o, mst_add_o, mst_wen_o,
    output mst_wdata_o, mst_be_o,
    input  mst_gnt_i, mst_r_valid_i, mst_r_rdata_i
  );

  modport master (
    output slv_req_i, slv_add_i, slv_wen_i,
    output slv_wdata_i, slv_be_i,
    input  slv_gnt_o, slv_r_valid_o, slv_r_rdata_o,
    input  mst_req_o, mst_add_o, mst_wen_o,
    input  mst_wdata_o, mst_be_o,
    output mst_gnt_i, mst_r_valid_i, mst_r_rdata_i
  );

endinterface

// File: rtl/tcdm_g_port_split.sv
// One wide TCDM port: lane issue under partial grants, response merge.
// TCDM_G_SLAVE_LANE_OFFSET_EN adds lane*ADDR_OFFSET to each lane address.
module tcdm_g_port_split
  import tcdm_g_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned DW          = 32,
  parameter int unsigned BW          = DW / 8,
  parameter int unsigned SIZE        = TCDM_SIZE,
  parameter int unsigned ADDR_OFFSET = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_i,
  input  logic [AW-1:0]            add_i,
  input  logic                     wen_i,
  input  logic [SIZE*DW-1:0]       wdata_i,
  input  logic [SIZE*BW-1:0]       be_i,
  output logic                     gnt_o,
  output logic                     r_valid_o,
  output logic [SIZE*DW-1:0]       r_rdata_o,
  output logic [SIZE-1:0]          lreq_o,
  output logic [SIZE-1:0][AW-1:0]  ladd_o,
  output logic [SIZE-1:0]          lwen_o,
  output logic [SIZE-1:0][DW-1:0]  lwdata_o,
  output logic [SIZE-1:0][BW-1:0]  lbe_o,
  input  logic [SIZE-1:0]          lgnt_i,
  input  logic [SIZE-1:0]          lr_valid_i,
  input  logic [SIZE-1:0][DW-1:0]  lr_rdata_i
);

`ifdef TCDM_G_SLAVE_LANE_OFFSET_EN
  localparam bit LANE_OFS_EN = 1'b1;
`else
  localparam bit LANE_OFS_EN = 1'b0;
`endif

  localparam logic [AW-1:0] STRIDE =
    LANE_OFS_EN ? AW'(ADDR_OFFSET) : '0;

  logic [SIZE-1:0]         issued_q, issued_d;
  logic [SIZE-1:0]         captured_q, captured_d;
  logic [SIZE-1:0]         lane_cov;
  logic [SIZE-1:0][DW-1:0] buf_q, buf_d;
  logic                    r_valid_q, r_valid_d;
  logic [SIZE-1:0][DW-1:0] r_rdata_q, r_rdata_d;

  // Fan the wide request out; granted lanes stay masked.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      lreq_o[i]   = req_i & ~issued_q[i];
      ladd_o[i]   = add_i + AW'(i) * STRIDE;
      lwen_o[i]   = wen_i;
      lwdata_o[i] = wdata_i[lane_lo(i, DW) +: DW];
      lbe_o[i]    = be_i[lane_lo(i, BW) +: BW];
    end
  end

  // Wide grant once every lane is issued or granted now.
  always_comb begin
    gnt_o    = req_i & (&(issued_q | lgnt_i));
    issued_d = issued_q | (lreq_o & lgnt_i);
    if (gnt_o) issued_d = '0;
  end

  // Collect lane responses; fire when all lanes are covered.
  always_comb begin
    buf_d = buf_q;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (lr_valid_i[i]) buf_d[i] = lr_rdata_i[i];
    end
    lane_cov   = captured_q | lr_valid_i;
    r_valid_d  = &lane_cov;
    captured_d = r_valid_d ? '0 : lane_cov;
    r_rdata_d  = r_valid_d ? buf_d : r_rdata_q;
  end

  // Issue/capture state and registered merged response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q   <= '0;
      captured_q <= '0;
      buf_q      <= '0;
      r_valid_q  <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      issued_q   <= issued_d;
      captured_q <= captured_d;
      buf_q      <= buf_d;
      r_valid_q  <= r_valid_d;
      r_rdata_q  <= r_rdata_d;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_rdata_o = r_rdata_q;

  a_no_double_rvalid: assert property (
    @(posedge clk) disable iff (!rst_n)
    (lr_valid_i & captured_q) == '0
  );

endmodule

// File: rtl/tcdm_g_slave_split.sv
// Splits NPX wide TCDM ports into SIZE x NPX bank ports.
// Option macro: TCDM_G_SLAVE_LANE_OFFSET_EN (per-lane address stride).
module tcdm_g_slave_split
  import tcdm_g_pkg::*;
#(
  parameter int unsigned ADDR_SRAM_WIDTH = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned SIZE            = TCDM_SIZE,
  parameter int unsigned NPX             = 4,
  parameter int unsigned ADDR_OFFSET     = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  tcdm_g_slave_split_if.slave bus
);

  localparam int unsigned AW = ADDR_SRAM_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned BW = BE_WIDTH;

  for (genvar j = 0; j < NPX; j++) begin : g_port
    logic [SIZE-1:0]         lreq, lwen, lgnt, lrv;
    logic [SIZE-1:0][AW-1:0] ladd;
    logic [SIZE-1:0][DW-1:0] lwdata, lrdata;
    logic [SIZE-1:0][BW-1:0] lbe;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
      assign bus.mst_req_o[i][j]   = lreq[i];
      assign bus.mst_add_o[i][j]   = ladd[i];
      assign bus.mst_wen_o[i][j]   = lwen[i];
      assign bus.mst_wdata_o[i][j] = lwdata[i];
      assign bus.mst_be_o[i][j]    = lbe[i];
      assign lgnt[i]   = bus.mst_gnt_i[i][j];
      assign lrv[i]    = bus.mst_r_valid_i[i][j];
      assign lrdata[i] = bus.mst_r_rdata_i[i][j];
    end

    tcdm_g_port_split #(
      .AW          (AW),
      .DW          (DW),
      .BW          (BW),
      .SIZE        (SIZE),
      .ADDR_OFFSET (ADDR_OFFSET)
    ) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (bus.slv_req_i[j]),
      .add_i      (bus.slv_add_i[j]),
      .wen_i      (bus.slv_wen_i[j]),
      .wdata_i    (bus.slv_wdata_i[j]),
      .be_i       (bus.slv_be_i[j]),
      .gnt_o      (bus.slv_gnt_o[j]),
      .r_valid_o  (bus.slv_r_valid_o[j]),
      .r_rdata_o  (bus.slv_r_rdata_o[j]),
      .lreq_o     (lreq),
      .ladd_o     (ladd),
      .lwen_o     (lwen),
      .lwdata_o   (lwdata),
      .lbe_o      (lbe),
      .lgnt_i     (lgnt),
      .lr_valid_i (lrv),
      .lr_rdata_i (lrdata)
    );
  end

endmodule
